// File: rtl/bus_target_regfile.sv
// bus_target_regfile
// Target end of the chipselect/start/read/write system-bus handshake, backed by
// a flop-based register file of 2**ADDR_BITS 32-bit words with byte-enable
// writes. A programmable number of wait states sits between accepting a
// transaction and touching the array.
//
// Optional build macro: BUS_TARGET_WPROT_EN
//   defined   -> adds i_wprot / o_werr; writes reaching ACCESS while i_wprot=1
//                leave the array untouched and set a sticky o_werr
//   undefined -> no protection ports, every write updates the array
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for chipselect & start & (read|write)
// ST_WAIT  | counting down wait states; abort if master withdraws
// ST_ACCESS| one cycle: perform the array read or byte-masked write
// ST_DONE  | ready=1, readdata stable until master drops its request

module bus_target_regfile #(
   parameter int ADDR_BITS   = 4,
   parameter int WAIT_STATES = 2
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_chipselect,
   input  logic        i_start,
   input  logic        i_read,
   input  logic        i_write,
   input  logic [31:0] i_address,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_writedata,
`ifdef BUS_TARGET_WPROT_EN
   input  logic        i_wprot,
   output logic        o_werr,
`endif
   output logic [31:0] o_readdata,
   output logic        o_ready,
   output logic        o_busy
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   // Parameter sanity: the wait counter is 4 bits wide and the word index
   // must fit inside the 32-bit byte address above the two byte-offset bits.
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("bus_target_regfile: WAIT_STATES must be in 0..15");
   end
   if (ADDR_BITS < 1 || ADDR_BITS > 29) begin : g_bad_addr_bits
      $error("bus_target_regfile: ADDR_BITS must be in 1..29");
   end

   localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [ADDR_BITS-1:0]   r_idx;
   logic [3:0]             r_be;
   logic [31:0]            r_wdata;
   logic                   r_kind_wr;
   logic [3:0]             r_cnt;
   logic [31:0]            r_readdata;
   logic [31:0]            r_mem [DEPTH];

   logic                   w_req;
   logic                   w_hold;
   logic                   w_accept;
   logic                   w_cnt_dec;
   logic                   w_do_access;
   logic                   w_commit;
   logic [31:0]            w_cur;
   logic [31:0]            w_merged;
   logic                   w_unused_addr;

   assign w_req  = i_read | i_write;
   assign w_hold = i_chipselect & w_req;
   assign w_cur  = r_mem[r_idx];

   // Only the word-index bits of the byte address are decoded.
   assign w_unused_addr = ^{i_address[31:ADDR_BITS+2], i_address[1:0]};

`ifdef BUS_TARGET_WPROT_EN
   logic r_werr;

   assign w_commit = r_kind_wr & ~i_wprot;
   assign o_werr   = r_werr;

   // Sticky protection-violation flag, cleared only by reset.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_werr <= 1'b0;
      end else if (w_do_access && r_kind_wr && i_wprot) begin
         r_werr <= 1'b1;
      end
   end
`else
   assign w_commit = r_kind_wr;
`endif

   // State register.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_cnt_dec   = 1'b0;
      w_do_access = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_chipselect && i_start && w_req) begin
               w_accept = 1'b1;
               w_next   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Withdrawal is honoured even on the last wait cycle, so an
            // aborted write never reaches the array.
            if (!w_hold) begin
               w_next = ST_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_next = ST_ACCESS;
            end else begin
               w_cnt_dec = 1'b1;
            end
         end
         ST_ACCESS: begin
            w_do_access = 1'b1;
            w_next      = ST_DONE;
         end
         ST_DONE: begin
            if (!w_hold) begin
               w_next = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Capture the transaction on accept and run the wait-state down-counter.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_idx     <= '0;
         r_be      <= '0;
         r_wdata   <= '0;
         r_kind_wr <= 1'b0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_idx     <= i_address[ADDR_BITS+1:2];
         r_be      <= i_be;
         r_wdata   <= i_writedata;
         r_kind_wr <= i_write;
         r_cnt     <= LP_WAIT;
      end else if (w_cnt_dec) begin
         r_cnt     <= r_cnt - 4'd1;
      end
   end

   // Byte-lane merge of the latched write data into the addressed word.
   always_comb begin
      w_merged = w_cur;
      for (int b = 0; b < 4; b++) begin
         if (r_be[b]) begin
            w_merged[8*b +: 8] = r_wdata[8*b +: 8];
         end
      end
   end

   // Register file: cleared by reset, written only in ACCESS.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_access && w_commit) begin
         r_mem[r_idx] <= w_merged;
      end
   end

   // Read-data register: loaded in ACCESS with the post-operation word, held otherwise.
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_readdata <= '0;
      end else if (w_do_access) begin
         r_readdata <= w_commit ? w_merged : w_cur;
      end
   end

   assign o_readdata = r_readdata;
   assign o_ready    = (r_state == ST_DONE);
   assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_target_regfile.sv
// Self-checking bench for bus_target_regfile (ADDR_BITS=4, WAIT_STATES=2):
// a directed vector table, hand-written abort/hold/reset sequences and a
// randomized phase checked against an array model of the register file.

module tb_bus_target_regfile;

   localparam int WS  = 2;
   localparam int LAT = 2 + WS;

   logic        clk;
   logic        rst_n;
   logic        cs;
   logic        start;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
`ifdef BUS_TARGET_WPROT_EN
   logic        wprot;
   logic        werr;
`endif

   int          n_checks;
   int          n_fail;
   logic [31:0] model [16];

   bus_target_regfile #(.ADDR_BITS(4), .WAIT_STATES(WS)) dut (
      .i_clock      (clk),
      .i_reset_n    (rst_n),
      .i_chipselect (cs),
      .i_start      (start),
      .i_read       (rd),
      .i_write      (wr),
      .i_address    (addr),
      .i_be         (be),
      .i_writedata  (wdata),
`ifdef BUS_TARGET_WPROT_EN
      .i_wprot      (wprot),
      .o_werr       (werr),
`endif
      .o_readdata   (rdata),
      .o_ready      (ready),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
   endtask

   task automatic model_write(input logic [3:0] idx, input logic [3:0] bmask, input logic [31:0] d);
      logic [31:0] w;
      w = model[idx];
      for (int b = 0; b < 4; b++)
         if (bmask[b]) w[8*b +: 8] = d[8*b +: 8];
      model[idx] = w;
   endtask

   function automatic logic [31:0] mk_addr(input logic [3:0] idx);
      logic [31:0] a;
      a = $urandom;
      a[5:2] = idx;
      return a;
   endfunction

   task automatic idle_inputs();
      cs = 1'b0; start = 1'b0; rd = 1'b0; wr = 1'b0;
      addr = $urandom; be = 4'($urandom); wdata = $urandom;
   endtask

   // Full handshake starting and ending on a negedge. Inputs other than
   // read/write/chipselect are scrambled after the start edge to prove they
   // were latched. Read is held hold_cyc cycles past the first ready.
   task automatic do_txn(input bit w, input bit r, input logic [3:0] idx,
                         input logic [3:0] bmask, input logic [31:0] d,
                         input logic [31:0] exp, input int hold_cyc, input string nm);
      logic [31:0] a;
      int          lat;
      bit          got;
      a = mk_addr(idx);
      cs = 1'b1; start = 1'b1; wr = w; rd = r; addr = a; be = bmask; wdata = d;
      @(posedge clk); @(negedge clk);
      start = 1'b0; addr = ~a; be = ~bmask; wdata = ~d;
      got = 1'b0; lat = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge clk); @(negedge clk);
         if (ready) begin got = 1'b1; lat = k; end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout actual=no_ready required=ready_within_40", nm);
         idle_inputs();
         return;
      end
      check32({nm, "_latency"}, 32'(lat), 32'(LAT));
      check32({nm, "_rdata"}, rdata, exp);
      for (int h = 1; h <= hold_cyc; h++) begin
         start = (h == 1);
         @(posedge clk); @(negedge clk);
         check32({nm, "_hold_ready"}, {31'b0, ready}, 32'd1);
         check32({nm, "_hold_rdata"}, rdata, exp);
      end
      start = 1'b0;
      if ($urandom_range(0, 1) == 0) begin rd = 1'b0; wr = 1'b0; end
      else cs = 1'b0;
      @(posedge clk); @(negedge clk);
      check32({nm, "_ready_drop"}, {31'b0, ready}, 32'd0);
      check32({nm, "_busy_drop"}, {31'b0, busy}, 32'd0);
      check32({nm, "_rdata_kept"}, rdata, exp);
      idle_inputs();
   endtask

   typedef struct {
      bit          w;
      bit          r;
      logic [3:0]  idx;
      logic [3:0]  bmask;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [31:0] a;
      logic [31:0] e;
      bit          seen;
      int          op;
      logic [3:0]  ridx;
      logic [3:0]  rbe;
      logic [31:0] rd32;

      n_checks = 0;
      n_fail   = 0;

      vecs[0]  = '{1'b1, 1'b0, 4'h2, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 1'b1, 4'h2, 4'h0, 32'h0,        32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b0, 4'h1, 4'hF, 32'h11223344, 32'h11223344};
      vecs[3]  = '{1'b1, 1'b0, 4'h1, 4'h5, 32'hAABBCCDD, 32'h11BB33DD};
      vecs[4]  = '{1'b0, 1'b1, 4'h1, 4'h0, 32'h0,        32'h11BB33DD};
      vecs[5]  = '{1'b1, 1'b0, 4'h3, 4'h0, 32'hFFFFFFFF, 32'h00000000};
      vecs[6]  = '{1'b0, 1'b1, 4'h3, 4'hA, 32'h0,        32'h00000000};
      vecs[7]  = '{1'b1, 1'b0, 4'hF, 4'h8, 32'hA5123456, 32'hA5000000};
      vecs[8]  = '{1'b0, 1'b1, 4'hF, 4'h0, 32'h0,        32'hA5000000};
      vecs[9]  = '{1'b1, 1'b1, 4'h4, 4'h3, 32'h9999BEEF, 32'h0000BEEF};
      vecs[10] = '{1'b0, 1'b1, 4'h4, 4'h0, 32'h0,        32'h0000BEEF};
      vecs[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 32'h0,        32'h00000000};

`ifdef BUS_TARGET_WPROT_EN
      wprot = 1'b0;
`endif
      idle_inputs();
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      check32("reset_ready", {31'b0, ready}, 32'd0);
      check32("reset_busy", {31'b0, busy}, 32'd0);
      check32("reset_rdata", rdata, 32'h0);

      // Directed vector table.
      for (int i = 0; i < 12; i++) begin
         do_txn(vecs[i].w, vecs[i].r, vecs[i].idx, vecs[i].bmask, vecs[i].d,
                vecs[i].exp, 0, $sformatf("vec%0d", i));
         if (vecs[i].w) model_write(vecs[i].idx, vecs[i].bmask, vecs[i].d);
      end

      // Start without chipselect, and start without read/write, are ignored.
      cs = 1'b0; start = 1'b1; rd = 1'b1; addr = mk_addr(4'h2);
      @(posedge clk); @(negedge clk);
      check32("nocs_busy", {31'b0, busy}, 32'd0);
      cs = 1'b1; rd = 1'b0; wr = 1'b0;
      @(posedge clk); @(negedge clk);
      check32("noreq_busy", {31'b0, busy}, 32'd0);
      idle_inputs();

      // Abort: write dropped on the last wait cycle never lands.
      a = mk_addr(4'h5);
      cs = 1'b1; start = 1'b1; wr = 1'b1; addr = a; be = 4'hF; wdata = 32'h12345678;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check32("abort_busy_wait", {31'b0, busy}, 32'd1);
      repeat (WS) begin @(posedge clk); @(negedge clk); end
      wr = 1'b0;
      seen = 1'b0;
      @(posedge clk); @(negedge clk);
      check32("abort_busy_idle", {31'b0, busy}, 32'd0);
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         if (ready) seen = 1'b1;
      end
      check32("abort_no_ready", {31'b0, seen}, 32'd0);
      idle_inputs();
      do_txn(1'b0, 1'b1, 4'h5, 4'h0, 32'h0, model[5], 0, "abort_after_read");

      // Abort by chipselect drop during the first wait cycle of a read.
      cs = 1'b1; start = 1'b1; rd = 1'b1; addr = mk_addr(4'h1);
      @(posedge clk); @(negedge clk);
      start = 1'b0; cs = 1'b0;
      @(posedge clk); @(negedge clk);
      check32("csabort_busy", {31'b0, busy}, 32'd0);
      check32("csabort_ready", {31'b0, ready}, 32'd0);
      idle_inputs();

      // Hold: read held five cycles past ready, with a stray start pulse.
      do_txn(1'b0, 1'b1, 4'h1, 4'h0, 32'h0, 32'h11BB33DD, 5, "hold");

      // Randomized traffic against the array model.
      for (int t = 0; t < 150; t++) begin
         op   = $urandom_range(0, 2);
         ridx = 4'($urandom);
         rbe  = 4'($urandom);
         rd32 = $urandom;
         if (op != 0) model_write(ridx, rbe, rd32);
         e = model[ridx];
         do_txn(op != 0, op != 1, ridx, rbe, rd32, e, $urandom_range(0, 2),
                $sformatf("rnd%0d", t));
      end

`ifdef BUS_TARGET_WPROT_EN
      // Protected write: handshake completes, array unchanged, werr sticky.
      wprot = 1'b1;
      do_txn(1'b1, 1'b0, 4'h0, 4'hF, 32'h12345678, model[0], 0, "wprot_write");
      check32("wprot_werr_set", {31'b0, werr}, 32'd1);
      wprot = 1'b0;
      do_txn(1'b0, 1'b1, 4'h0, 4'h0, 32'h0, model[0], 0, "wprot_readback");
      check32("wprot_werr_sticky", {31'b0, werr}, 32'd1);
`endif

      // Reset during ACCESS of a write to 0x0C.
      do_txn(1'b1, 1'b0, 4'h7, 4'hF, 32'h5A5A5A5A, 32'h5A5A5A5A, 0, "pre_reset");
      model_write(4'h7, 4'hF, 32'h5A5A5A5A);
      cs = 1'b1; start = 1'b1; wr = 1'b1; addr = mk_addr(4'h3); be = 4'hF; wdata = 32'hCAFEF00D;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (WS + 1) begin @(posedge clk); @(negedge clk); end
      check32("midrst_not_ready", {31'b0, ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check32("midrst_ready", {31'b0, ready}, 32'd0);
      check32("midrst_rdata", rdata, 32'h0);
      check32("midrst_busy", {31'b0, busy}, 32'd0);
`ifdef BUS_TARGET_WPROT_EN
      check32("midrst_werr", {31'b0, werr}, 32'd0);
`endif
      rst_n = 1'b1;
      idle_inputs();
      model_clear();
      @(posedge clk); @(negedge clk);
      do_txn(1'b0, 1'b1, 4'h3, 4'h0, 32'h0, 32'h0, 0, "midrst_word0c");
      do_txn(1'b0, 1'b1, 4'h7, 4'h0, 32'h0, 32'h0, 0, "midrst_word1c");
      do_txn(1'b0, 1'b1, 4'h2, 4'h0, 32'h0, 32'h0, 0, "midrst_word08");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
